// File: rtl/mips_pkg.sv
// Shared MIPS encodings, FSM states and datapath select codes
// for the multicycle control sequencer.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_SYSCALL = 6'h0c;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_SLT     = 6'h2a;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXEC    = 4'd2,
      S_MEM     = 4'd3,
      S_WB      = 4'd4,
      S_SYSCALL = 4'd5,
      S_HALT    = 4'd6
   } state_t;

   typedef enum logic [3:0] {
      C_ILLEGAL, C_RTYPE, C_IALU, C_LW, C_SW, C_BEQ,
      C_BNE, C_J, C_JAL, C_JR, C_SYSCALL
   } cls_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_RS     = 2'd3;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MEM = 2'd1;
   localparam logic [1:0] M2R_PC4 = 2'd2;

   localparam logic [2:0] SRCB_RT   = 3'd0;
   localparam logic [2:0] SRCB_FOUR = 3'd1;
   localparam logic [2:0] SRCB_SEXT = 3'd2;
   localparam logic [2:0] SRCB_ZEXT = 3'd3;
   localparam logic [2:0] SRCB_BR   = 3'd4;
   localparam logic [2:0] SRCB_LUI  = 3'd5;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   localparam int SYS_EXIT = 10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: IR opcode/funct to instruction
// class plus the ALU operation and operand selects used in EXEC.
module mc_decode
   import mips_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output cls_t       cls,
   output logic [2:0] alu_op,
   output logic       alu_src_a,
   output logic [2:0] alu_src_b,
   output logic       illegal
);

   always_comb begin
      cls       = C_ILLEGAL;
      alu_op    = ALU_AND;
      alu_src_a = 1'b0;
      alu_src_b = SRCB_RT;
      case (op)
         OP_RTYPE: begin
            alu_src_a = 1'b1;
            cls       = C_RTYPE;
            case (funct)
               FN_ADD:     alu_op = ALU_ADD;
               FN_SUB:     alu_op = ALU_SUB;
               FN_AND:     alu_op = ALU_AND;
               FN_OR:      alu_op = ALU_OR;
               FN_SLT:     alu_op = ALU_SLT;
               FN_JR: begin
                  cls       = C_JR;
                  alu_src_a = 1'b0;
               end
               FN_SYSCALL: begin
                  cls       = C_SYSCALL;
                  alu_src_a = 1'b0;
               end
               default: begin
                  cls       = C_ILLEGAL;
                  alu_src_a = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            cls       = C_IALU;
            alu_op    = ALU_ADD;
            alu_src_a = 1'b1;
            alu_src_b = SRCB_SEXT;
         end
         OP_ORI: begin
            cls       = C_IALU;
            alu_op    = ALU_OR;
            alu_src_a = 1'b1;
            alu_src_b = SRCB_ZEXT;
         end
         OP_SLTIU: begin
            cls       = C_IALU;
            alu_op    = ALU_SLT;
            alu_src_a = 1'b1;
            alu_src_b = SRCB_SEXT;
         end
         // rs is $zero for LUI, so ADD passes imm<<16 through
         OP_LUI: begin
            cls       = C_IALU;
            alu_op    = ALU_ADD;
            alu_src_a = 1'b1;
            alu_src_b = SRCB_LUI;
         end
         OP_LW, OP_SW: begin
            cls       = (op == OP_LW) ? C_LW : C_SW;
            alu_op    = ALU_ADD;
            alu_src_a = 1'b1;
            alu_src_b = SRCB_SEXT;
         end
         OP_BEQ, OP_BNE: begin
            cls       = (op == OP_BEQ) ? C_BEQ : C_BNE;
            alu_op    = ALU_SUB;
            alu_src_a = 1'b1;
            alu_src_b = SRCB_RT;
         end
         OP_J:    cls = C_J;
         OP_JAL:  cls = C_JAL;
         default: cls = C_ILLEGAL;
      endcase
   end

   assign illegal = (cls == C_ILLEGAL);

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: owns the IR fields, the memory wait
// counter, the retired-instruction counter and the sticky error state.
module mc_control
   import mips_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int TIMEOUT      = 0,
   parameter bit TRAP_ILLEGAL = 1'b1,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] instr,
   input  logic              mem_ready,
   input  logic              alu_zero,
   input  logic [DATA_W-1:0] vreg,
   input  logic              sys_ack,
   output logic              mem_read,
   output logic              mem_write,
   output logic              i_or_d,
   output logic              ir_write,
   output logic              pc_write,
   output logic              reg_write,
   output logic [1:0]        pc_src,
   output logic [1:0]        reg_dst,
   output logic [1:0]        mem_to_reg,
   output logic [2:0]        alu_op,
   output logic              alu_src_a,
   output logic [2:0]        alu_src_b,
   output logic              sys_valid,
   output logic              halted,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [CNT_W-1:0]  retired,
   output logic [3:0]        state
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t cur, nxt;
   logic [5:0] ir_op, ir_fn;
   logic [WAIT_W-1:0] wait_cnt;
   logic sys_exit;

   cls_t d_cls;
   logic [2:0] d_alu_op, d_src_b;
   logic d_src_a, d_illegal;

   logic pending, tmo, retire, set_err, sys_load;
   logic [1:0] code_nxt;

   // only the opcode/funct fields steer the sequencer
   logic unused_instr;
   assign unused_instr = ^instr;

   mc_decode u_decode (
      .op        (ir_op),
      .funct     (ir_fn),
      .cls       (d_cls),
      .alu_op    (d_alu_op),
      .alu_src_a (d_src_a),
      .alu_src_b (d_src_b),
      .illegal   (d_illegal)
   );

   assign pending = (cur == S_FETCH) || (cur == S_MEM);
   assign tmo = (TIMEOUT > 0) && pending && !mem_ready &&
                (wait_cnt == WAIT_W'(TIMEOUT - 1));

   always_comb begin
      nxt        = cur;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      pc_src     = PC_SEQ;
      reg_dst    = RD_RT;
      mem_to_reg = M2R_ALU;
      alu_op     = ALU_AND;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      sys_valid  = 1'b0;
      retire     = 1'b0;
      set_err    = 1'b0;
      code_nxt   = ERR_NONE;
      sys_load   = 1'b0;
      // reset gates every strobe combinationally, even mid-request
      if (!reset) begin
         case (cur)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               alu_op    = ALU_ADD;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  nxt      = S_DECODE;
               end else if (tmo) begin
                  set_err  = 1'b1;
                  code_nxt = ERR_TIMEOUT;
                  nxt      = S_HALT;
               end
            end
            S_DECODE: begin
               alu_src_b = SRCB_BR;
               alu_op    = ALU_ADD;
               if (!d_illegal) begin
                  nxt = S_EXEC;
               end else if (TRAP_ILLEGAL) begin
                  set_err  = 1'b1;
                  code_nxt = ERR_ILLEGAL;
                  nxt      = S_HALT;
               end else begin
                  retire = 1'b1;
                  nxt    = S_FETCH;
               end
            end
            S_EXEC: begin
               alu_op    = d_alu_op;
               alu_src_a = d_src_a;
               alu_src_b = d_src_b;
               case (d_cls)
                  C_RTYPE, C_IALU: nxt = S_WB;
                  C_LW, C_SW:      nxt = S_MEM;
                  C_BEQ, C_BNE: begin
                     pc_src   = PC_BRANCH;
                     pc_write = alu_zero ^ (d_cls == C_BNE);
                     retire   = 1'b1;
                     nxt      = S_FETCH;
                  end
                  C_J, C_JAL: begin
                     pc_src   = PC_JUMP;
                     pc_write = 1'b1;
                     if (d_cls == C_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = RD_RA;
                        mem_to_reg = M2R_PC4;
                     end
                     retire = 1'b1;
                     nxt    = S_FETCH;
                  end
                  C_JR: begin
                     pc_src   = PC_RS;
                     pc_write = 1'b1;
                     retire   = 1'b1;
                     nxt      = S_FETCH;
                  end
                  C_SYSCALL: begin
                     sys_load = 1'b1;
                     nxt      = S_SYSCALL;
                  end
                  default: nxt = S_FETCH;
               endcase
            end
            S_MEM: begin
               i_or_d    = 1'b1;
               mem_read  = (d_cls == C_LW);
               mem_write = (d_cls == C_SW);
               if (mem_ready) begin
                  if (d_cls == C_LW) begin
                     nxt = S_WB;
                  end else begin
                     retire = 1'b1;
                     nxt    = S_FETCH;
                  end
               end else if (tmo) begin
                  set_err  = 1'b1;
                  code_nxt = ERR_TIMEOUT;
                  nxt      = S_HALT;
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (d_cls == C_LW) ? M2R_MEM : M2R_ALU;
               reg_dst    = (d_cls == C_RTYPE) ? RD_RD : RD_RT;
               retire     = 1'b1;
               nxt        = S_FETCH;
            end
            S_SYSCALL: begin
               if (sys_exit) begin
                  retire = 1'b1;
                  nxt    = S_HALT;
               end else begin
                  sys_valid = 1'b1;
                  if (sys_ack) begin
                     retire = 1'b1;
                     nxt    = S_FETCH;
                  end
               end
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur      <= S_FETCH;
         ir_op    <= '0;
         ir_fn    <= '0;
         wait_cnt <= '0;
         sys_exit <= 1'b0;
         retired  <= '0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         cur <= nxt;
         if (ir_write) begin
            ir_op <= instr[31:26];
            ir_fn <= instr[5:0];
         end
         if (pending && !mem_ready)
            wait_cnt <= wait_cnt + WAIT_W'(1);
         else
            wait_cnt <= '0;
         // vreg is sampled once, on entry to SYSCALL
         if (sys_load)
            sys_exit <= (vreg == DATA_W'(SYS_EXIT));
         if (retire)
            retired <= retired + CNT_W'(1);
         if (set_err) begin
            err      <= 1'b1;
            err_code <= code_nxt;
         end
      end
   end

   assign halted = (cur == S_HALT);
   assign state  = cur;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus a
// randomized instruction stream against a per-instruction timing model.
module tb_mc_control;

   logic clk;
   logic reset;
   logic [31:0] instr, vreg;
   logic mem_ready, alu_zero, sys_ack;

   logic mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
   logic [1:0] pc_src, reg_dst, mem_to_reg, err_code;
   logic [2:0] alu_op, alu_src_b;
   logic alu_src_a, sys_valid, halted, err;
   logic [31:0] retired;
   logic [3:0] state;

   logic b_mem_read, b_mem_write, b_i_or_d, b_ir_write, b_pc_write;
   logic b_reg_write;
   logic [1:0] b_pc_src, b_reg_dst, b_mem_to_reg, b_err_code;
   logic [2:0] b_alu_op, b_alu_src_b;
   logic b_alu_src_a, b_sys_valid, b_halted, b_err;
   logic [31:0] b_retired;
   logic [3:0] b_state;

   int n_tests = 0;
   int n_fail  = 0;

   int o_cyc, o_regw, o_pcw, o_memw, o_memr, o_sysv, o_irw, o_bside;
   logic [1:0] o_rd, o_m2r, o_pcsrc;
   logic [31:0] o_ret0;
   bit o_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mc_control #(.DATA_W(32), .TIMEOUT(4), .TRAP_ILLEGAL(1'b1),
                .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .instr(instr),
      .mem_ready(mem_ready), .alu_zero(alu_zero), .vreg(vreg),
      .sys_ack(sys_ack), .mem_read(mem_read), .mem_write(mem_write),
      .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
      .reg_write(reg_write), .pc_src(pc_src), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_op(alu_op), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .sys_valid(sys_valid), .halted(halted),
      .err(err), .err_code(err_code), .retired(retired), .state(state)
   );

   mc_control #(.DATA_W(32), .TIMEOUT(0), .TRAP_ILLEGAL(1'b0),
                .CNT_W(32)) dut_b (
      .clk(clk), .reset(reset), .instr(instr),
      .mem_ready(mem_ready), .alu_zero(alu_zero), .vreg(vreg),
      .sys_ack(sys_ack), .mem_read(b_mem_read),
      .mem_write(b_mem_write), .i_or_d(b_i_or_d),
      .ir_write(b_ir_write), .pc_write(b_pc_write),
      .reg_write(b_reg_write), .pc_src(b_pc_src),
      .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
      .alu_op(b_alu_op), .alu_src_a(b_alu_src_a),
      .alu_src_b(b_alu_src_b), .sys_valid(b_sys_valid),
      .halted(b_halted), .err(b_err), .err_code(b_err_code),
      .retired(b_retired), .state(b_state)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b0;
      sys_ack = 1'b0;
      instr = '0;
      alu_zero = 1'b0;
      vreg = '0;
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   // drives one instruction with a reactive memory/host model
   task automatic run_instr(input logic [31:0] iw, input int wf,
                            input int wm, input logic az,
                            input logic [31:0] vr, input int ack_d);
      int wcnt, lim;
      instr = iw;
      alu_zero = az;
      vreg = vr;
      o_cyc = 0; o_regw = 0; o_pcw = 0; o_memw = 0; o_memr = 0;
      o_sysv = 0; o_irw = 0; o_bside = 0;
      o_rd = 0; o_m2r = 0; o_pcsrc = 0;
      o_ret0 = retired;
      o_done = 0;
      wcnt = 0;
      for (int c = 0; c < 60 && !o_done; c++) begin
         @(negedge clk);
         mem_ready = 1'b0;
         sys_ack = 1'b0;
         #1;
         if (mem_read || mem_write) begin
            lim = i_or_d ? wm : wf;
            if (wcnt >= lim) mem_ready = 1'b1;
            else wcnt++;
         end
         if (sys_valid) begin
            o_sysv++;
            if (o_sysv >= ack_d) sys_ack = 1'b1;
         end
         #1;
         o_cyc++;
         if (reg_write) begin
            o_regw++;
            o_rd = reg_dst;
            o_m2r = mem_to_reg;
         end
         if (pc_write && pc_src != 2'd0) begin
            o_pcw++;
            o_pcsrc = pc_src;
         end
         if (mem_write && mem_ready) o_memw++;
         if (mem_read && i_or_d && mem_ready) o_memr++;
         if (ir_write) o_irw++;
         if (b_reg_write || b_mem_write) o_bside++;
         if (mem_ready) wcnt = 0;
         @(posedge clk);
         #1;
         if (retired != o_ret0 || halted) o_done = 1;
      end
      mem_ready = 1'b0;
      sys_ack = 1'b0;
   endtask

   // per-instruction expectations straight from the ISA timing table
   task automatic model(input logic [31:0] iw, input int wf,
                        input int wm, input logic az, input int ack_d,
                        output int e_cyc, output int e_regw,
                        output int e_pcw, output int e_memw,
                        output int e_memr, output int e_sysv,
                        output logic [1:0] e_rd,
                        output logic [1:0] e_m2r,
                        output logic [1:0] e_pcsrc);
      logic [5:0] op, fn;
      op = iw[31:26];
      fn = iw[5:0];
      e_cyc = 0; e_regw = 0; e_pcw = 0; e_memw = 0; e_memr = 0;
      e_sysv = 0; e_rd = 0; e_m2r = 0; e_pcsrc = 0;
      case (op)
         6'h00: begin
            if (fn == 6'h08) begin
               e_cyc = 3 + wf; e_pcw = 1; e_pcsrc = 2'd3;
            end else if (fn == 6'h0c) begin
               e_cyc = 3 + wf + ack_d; e_sysv = ack_d;
            end else begin
               e_cyc = 4 + wf; e_regw = 1; e_rd = 2'd1;
            end
         end
         6'h08, 6'h09, 6'h0b, 6'h0d, 6'h0f: begin
            e_cyc = 4 + wf; e_regw = 1;
         end
         6'h23: begin
            e_cyc = 5 + wf + wm; e_regw = 1; e_m2r = 2'd1; e_memr = 1;
         end
         6'h2b: begin
            e_cyc = 4 + wf + wm; e_memw = 1;
         end
         6'h04, 6'h05: begin
            e_cyc = 3 + wf;
            e_pcw = ((op == 6'h05) != az) ? 1 : 0;
            e_pcsrc = (e_pcw == 1) ? 2'd1 : 2'd0;
         end
         6'h02: begin
            e_cyc = 3 + wf; e_pcw = 1; e_pcsrc = 2'd2;
         end
         6'h03: begin
            e_cyc = 3 + wf; e_pcw = 1; e_pcsrc = 2'd2;
            e_regw = 1; e_rd = 2'd2; e_m2r = 2'd2;
         end
         default: e_cyc = 0;
      endcase
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      sys_ack = 1'b1;
      #1;
      n_tests++;
      if ({mem_read, mem_write, ir_write, pc_write, reg_write,
           sys_valid} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_enables got %b want 000000",
                  {mem_read, mem_write, ir_write, pc_write, reg_write,
                   sys_valid});
      end
      n_tests++;
      if (state !== 4'd0 || retired !== 32'd0 || err !== 1'b0 ||
          halted !== 1'b0 || err_code !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state st=%0d ret=%0d err=%b halt=%b want 0",
                  state, retired, err, halted);
      end
      @(posedge clk);
      #2 reset = 1'b0;
      mem_ready = 1'b0;
      sys_ack = 1'b0;
      @(negedge clk);
      #1;
      n_tests++;
      if (mem_read !== 1'b1 || i_or_d !== 1'b0 || alu_src_b !== 3'd1 ||
          alu_op !== 3'b010 || alu_src_a !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_outputs rd=%b iod=%b b=%0d op=%b want 1 0 1 010",
                  mem_read, i_or_d, alu_src_b, alu_op);
      end
   endtask

   task automatic test_add();
      do_reset();
      run_instr(32'h00221820, 0, 0, 1'b0, 32'd0, 1);
      n_tests++;
      if (o_cyc !== 4 || o_regw !== 1 || o_rd !== 2'd1 ||
          o_m2r !== 2'd0) begin
         n_fail++;
         $display("FAIL add cyc=%0d regw=%0d rd=%0d m2r=%0d want 4 1 1 0",
                  o_cyc, o_regw, o_rd, o_m2r);
      end
      n_tests++;
      if (retired !== 32'd1) begin
         n_fail++;
         $display("FAIL add_retired got %0d want 1", retired);
      end
   endtask

   task automatic test_lw_wait();
      do_reset();
      run_instr(32'h8c220004, 0, 2, 1'b0, 32'd0, 1);
      n_tests++;
      if (o_cyc !== 7 || o_regw !== 1 || o_m2r !== 2'd1 ||
          o_rd !== 2'd0 || o_memr !== 1) begin
         n_fail++;
         $display("FAIL lw_wait cyc=%0d regw=%0d m2r=%0d rd=%0d want 7 1 1 0",
                  o_cyc, o_regw, o_m2r, o_rd);
      end
   endtask

   task automatic test_bne();
      do_reset();
      run_instr(32'h14220003, 0, 0, 1'b0, 32'd0, 1);
      n_tests++;
      if (o_cyc !== 3 || o_pcw !== 1 || o_pcsrc !== 2'd1) begin
         n_fail++;
         $display("FAIL bne_taken cyc=%0d pcw=%0d src=%0d want 3 1 1",
                  o_cyc, o_pcw, o_pcsrc);
      end
      run_instr(32'h14220003, 0, 0, 1'b1, 32'd0, 1);
      n_tests++;
      if (o_cyc !== 3 || o_pcw !== 0 || retired !== 32'd2) begin
         n_fail++;
         $display("FAIL bne_not_taken cyc=%0d pcw=%0d ret=%0d want 3 0 2",
                  o_cyc, o_pcw, retired);
      end
   endtask

   task automatic test_syscall();
      do_reset();
      run_instr(32'h0000000c, 0, 0, 1'b0, 32'd4, 5);
      n_tests++;
      if (o_sysv !== 5 || o_cyc !== 8 || state !== 4'd0) begin
         n_fail++;
         $display("FAIL syscall_ack sysv=%0d cyc=%0d st=%0d want 5 8 0",
                  o_sysv, o_cyc, state);
      end
      run_instr(32'h0000000c, 0, 0, 1'b0, 32'd10, 1);
      n_tests++;
      if (halted !== 1'b1 || o_sysv !== 0 || retired !== 32'd2 ||
          err !== 1'b0) begin
         n_fail++;
         $display("FAIL syscall_exit halt=%b sysv=%0d ret=%0d err=%b want 1 0 2 0",
                  halted, o_sysv, retired, err);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      run_instr(32'hfc000000, 0, 0, 1'b0, 32'd0, 1);
      n_tests++;
      if (err !== 1'b1 || err_code !== 2'd1 || halted !== 1'b1 ||
          retired !== 32'd0) begin
         n_fail++;
         $display("FAIL illegal_trap err=%b code=%0d halt=%b ret=%0d want 1 1 1 0",
                  err, err_code, halted, retired);
      end
      n_tests++;
      if (b_retired !== 32'd1 || b_err !== 1'b0 || o_bside !== 0 ||
          b_state !== 4'd0) begin
         n_fail++;
         $display("FAIL illegal_nop ret=%0d err=%b side=%0d st=%0d want 1 0 0 0",
                  b_retired, b_err, o_bside, b_state);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (halted !== 1'b1 || mem_read !== 1'b0 || err_code !== 2'd1) begin
         n_fail++;
         $display("FAIL halt_sticky halt=%b rd=%b code=%0d want 1 0 1",
                  halted, mem_read, err_code);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         mem_ready = 1'b0;
         @(posedge clk);
         #1;
         if (i == 3) begin
            n_tests++;
            if (err !== 1'b0) begin
               n_fail++;
               $display("FAIL timeout_early err=%b want 0", err);
            end
         end
      end
      n_tests++;
      if (err !== 1'b1 || err_code !== 2'd2 || halted !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout err=%b code=%0d halt=%b want 1 2 1",
                  err, err_code, halted);
      end
   endtask

   task automatic test_timeout_boundary();
      do_reset();
      run_instr(32'h8c220004, 3, 3, 1'b0, 32'd0, 1);
      n_tests++;
      if (o_cyc !== 11 || err !== 1'b0 || retired !== 32'd1) begin
         n_fail++;
         $display("FAIL ready_beats_timeout cyc=%0d err=%b ret=%0d want 11 0 1",
                  o_cyc, err, retired);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      n_tests++;
      if (mem_read !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_req_pending rd=%b want 1", mem_read);
      end
      #1 reset = 1'b1;
      #1;
      n_tests++;
      if ({mem_read, mem_write, ir_write, pc_write, reg_write,
           alu_src_b, alu_op} !== 11'b0) begin
         n_fail++;
         $display("FAIL mid_req_reset outs=%b want 0",
                  {mem_read, mem_write, ir_write, pc_write, reg_write,
                   alu_src_b, alu_op});
      end
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] iw, vr;
      logic az;
      int wf, wm, ack_d, k, bad;
      int e_cyc, e_regw, e_pcw, e_memw, e_memr, e_sysv;
      logic [1:0] e_rd, e_m2r, e_pcsrc;
      logic [5:0] rfn [5];
      logic [5:0] iop [9];
      rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      iop = '{6'h08, 6'h09, 6'h0b, 6'h0d, 6'h0f, 6'h23, 6'h2b,
              6'h04, 6'h05};
      do_reset();
      for (int n = 0; n < 80; n++) begin
         iw = $urandom;
         k = $urandom_range(0, 11);
         if (k == 0)
            iw = {6'h00, iw[25:6], rfn[$urandom_range(0, 4)]};
         else if (k == 1) iw = {6'h00, iw[25:6], 6'h08};
         else if (k == 2) iw = {6'h00, iw[25:6], 6'h0c};
         else if (k == 3) iw = {6'h02, iw[25:0]};
         else if (k == 4) iw = {6'h03, iw[25:0]};
         else iw = {iop[$urandom_range(0, 8)], iw[25:0]};
         wf = $urandom_range(0, 3);
         wm = $urandom_range(0, 3);
         az = 1'($urandom_range(0, 1));
         ack_d = $urandom_range(1, 4);
         vr = $urandom;
         if (vr == 32'd10) vr = 32'd4;
         model(iw, wf, wm, az, ack_d, e_cyc, e_regw, e_pcw, e_memw,
               e_memr, e_sysv, e_rd, e_m2r, e_pcsrc);
         run_instr(iw, wf, wm, az, vr, ack_d);
         bad = 0;
         if (o_cyc !== e_cyc || o_regw !== e_regw ||
             o_pcw !== e_pcw || o_memw !== e_memw ||
             o_memr !== e_memr || o_sysv !== e_sysv || o_irw !== 1)
            bad = 1;
         if (e_regw == 1 && (o_rd !== e_rd || o_m2r !== e_m2r))
            bad = 1;
         if (e_pcw == 1 && o_pcsrc !== e_pcsrc)
            bad = 1;
         if (retired !== o_ret0 + 32'd1 || err !== 1'b0 ||
             halted !== 1'b0)
            bad = 1;
         n_tests++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL rand[%0d] iw=%h cyc=%0d/%0d regw=%0d/%0d rd=%0d/%0d m2r=%0d/%0d pcw=%0d/%0d src=%0d/%0d memw=%0d/%0d memr=%0d/%0d sysv=%0d/%0d ret=%0d err=%b (got/want)",
                     n, iw, o_cyc, e_cyc, o_regw, e_regw, o_rd, e_rd,
                     o_m2r, e_m2r, o_pcw, e_pcw, o_pcsrc, e_pcsrc,
                     o_memw, e_memw, o_memr, e_memr, o_sysv, e_sysv,
                     retired - o_ret0, err);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      instr = '0;
      vreg = '0;
      mem_ready = 1'b0;
      alu_zero = 1'b0;
      sys_ack = 1'b0;
      test_reset();
      test_add();
      test_lw_wait();
      test_bne();
      test_syscall();
      test_illegal();
      test_timeout();
      test_timeout_boundary();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control sequencer for the MIPS core; the successor to the single-cycle combinational decoder. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB states against a variable-latency memory handshake. Latches the instruction word internally and handles SYSCALL through a host handshake instead of simulator calls. Drives every datapath select and enable, and flags illegal instructions and memory timeouts.

## Interface
- DATA_W, 32: instruction/vreg width (≥32; opcode = [31:26], funct = [5:0]).
- TIMEOUT, 0: max cycles waiting on `mem_ready`; 0 disables the timeout.
- TRAP_ILLEGAL, 1: 1 → illegal instruction halts; 0 → executed as NOP.
- CNT_W, 32: width of retired-instruction counter.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instr  in  DATA_W  memory read data; latched into IR on fetch completion.
- mem_ready  in  1  memory completes the current access this cycle.
- alu_zero  in  1  ALU zero flag, sampled in EXEC for BEQ/BNE.
- vreg  in  DATA_W  $v0 value, sampled in SYSCALL.
- sys_ack  in  1  host done with syscall.
- mem_read, mem_write  out  1  memory request strobes, held until `mem_ready`.
- i_or_d  out  1  0 = PC address, 1 = ALU result address.
- ir_write, pc_write, reg_write  out  1  register enables (single-cycle pulses).
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (JR).
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $ra.
- mem_to_reg  out  2  0 = ALU, 1 = memory, 2 = PC+4.
- alu_op  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  3  0 rt, 1 const 4, 2 sext imm, 3 zext imm, 4 sext imm<<2, 5 imm<<16.
- sys_valid  out  1  syscall pending; held until `sys_ack`.
- halted, err  out  1  sticky; only reset clears them.
- err_code  out  2  0 none, 1 illegal, 2 mem timeout.
- retired  out  CNT_W  instructions retired, wraps modulo 2^CNT_W.
- state  out  4  current state, for debug.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, SYSCALL, HALT.
- FETCH:
  - Assert mem_read, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - On mem_ready: ir_write, pc_write with pc_src=0, then → DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=4, alu_op=ADD (branch target).
  - Dispatch on IR opcode/funct; unknown encoding → illegal.
- EXEC:
  - R-type ADD/SUB/AND/OR/SLT: alu_src_a=1, alu_src_b=0 → WB with reg_dst=1.
  - ADDI/ADDIU: sext ADD. ORI: zext OR. SLTIU: sext SLT. LUI: alu_src_b=5, ADD with rs (rs=$zero by ISA).
  - LW/SW: sext ADD → MEM.
  - BEQ/BNE: SUB rs−rt; pc_write with pc_src=1 iff (alu_zero ^ BNE); → FETCH (retire).
  - J: pc_src=2, pc_write → FETCH. JAL: additionally reg_write, reg_dst=2, mem_to_reg=2, same cycle.
  - JR: pc_src=3, pc_write → FETCH. SYSCALL → SYSCALL.
- MEM: i_or_d=1, mem_read (LW) or mem_write (SW), held until mem_ready. SW → FETCH (retire); LW → WB.
- WB: reg_write with mem_to_reg=1 (LW) or 0 (ALU); reg_dst=0 for I-type → FETCH (retire).
- SYSCALL: sample vreg on entry.
  - vreg=10 → HALT (retire).
  - Any other value: assert sys_valid until sys_ack, then → FETCH (retire). Host decodes vreg (4 = print string; others unsupported).
- Illegal instruction:
  - TRAP_ILLEGAL=1: err=1, err_code=1 → HALT.
  - TRAP_ILLEGAL=0: no register/memory side effect, retire, → FETCH.
- Timeout: with TIMEOUT>0, a wait counter runs while a request is pending. Reaching TIMEOUT without mem_ready → err, err_code=2, HALT.
- HALT: all enables 0, halted=1; stays until reset.
- Every non-listed output is 0 in every state. Enables never assert on the same edge as reset.

## Timing
- Reset (async): state=FETCH, IR=0, all outputs 0, retired=0, err/halted=0.
- Zero-wait memory cycle counts: branch/J/JAL/JR 3; R-type/I-ALU/SW 4; LW 5; SYSCALL 3 + ack wait.
- Each wait cycle on mem_ready adds one cycle in FETCH or MEM.
- mem_ready and a timeout expiring in the same cycle: mem_ready wins.
- retired increments on the edge leaving the final state of each instruction.
- sys_ack in the same cycle as sys_valid first rises: accepted, leave next edge.
- Reset mid-request drops mem_read/mem_write immediately (async).

## Structure
- Shared package `mips_pkg` holds:
  - Opcode/funct constants already used by the core's header.
  - State enum.
  - ALU op codes.
  - pc_src/reg_dst/mem_to_reg/alu_src_b encodings.
- One sub-module, `mc_decode`: combinational IR → instruction class, ALU op, operand selects, illegal flag. The top holds the FSM, IR, wait counter, and retired counter.

## Test plan
- ADD $3,$1,$2 (0x00221820), mem_ready always 1 → 4 cycles, reg_write with reg_dst=1 in cycle 4, retired=1.
- LW with mem_ready low 2 cycles in MEM → 7 cycles total, WB has mem_to_reg=1, reg_dst=0.
- BNE (0x14220003) with alu_zero=0 → pc_write with pc_src=1 in EXEC. Same instruction with alu_zero=1 → no pc_write.
- SYSCALL, vreg=4, sys_ack after 5 cycles → sys_valid high exactly 5 cycles, then FETCH. vreg=10 → halted=1, no sys_valid.
- Opcode 0x3F with TRAP_ILLEGAL=1 → err=1, err_code=1, HALT. With TRAP_ILLEGAL=0 → no reg_write/mem_write, retired+1.
- TIMEOUT=4, mem_ready held low in FETCH → err_code=2 after 4 cycles. Reset asserted mid-wait → all outputs 0 asynchronously.
